// File: rtl/codec_tdm_port.sv
// TDM serial port to the AK4619 codec: BICK/LRCK generation, 4-slot ADC capture, 4-slot DAC shift-out.
// Build option CODEC_LOOPBACK_EN: the rx path samples the internal sdin register instead of sdout.

module codec_tdm_port #(
  parameter int unsigned W         = 16,
  parameter int unsigned SLOT_BITS = 32,
  parameter int unsigned N_SLOTS   = 4,
  parameter int unsigned BCLK_DIV  = 4
) (
  input  logic         clk,
  input  logic         rst,
  output logic         bick,
  output logic         lrck,
  output logic         sdin,
  input  logic         sdout,
  output logic         sample_clk,
  input  logic [W-1:0] dac0,
  input  logic [W-1:0] dac1,
  input  logic [W-1:0] dac2,
  input  logic [W-1:0] dac3,
  output logic [W-1:0] adc0,
  output logic [W-1:0] adc1,
  output logic [W-1:0] adc2,
  output logic [W-1:0] adc3
);

  localparam int unsigned FRAME = N_SLOTS * SLOT_BITS;
  localparam int unsigned BW    = $clog2(FRAME);
  localparam int unsigned DW    = $clog2(BCLK_DIV);
  localparam int unsigned FW    = N_SLOTS * W;
  localparam int unsigned IW    = $clog2(FW);

  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
  localparam logic [DW-1:0] DIV_RISE = DW'(BCLK_DIV / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME - 1);
  localparam logic [BW-1:0] BIT_HALF = BW'(FRAME / 2);

  logic [DW-1:0] div_cnt, div_nxt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic          fall_ev, rise_ev, frame_start;
  logic [FW-1:0] dac_frame, tx_frame, tx_src, rx_frame, rx_nxt;
  logic [IW:0]   tx_map, rx_map;
  logic          rx_din;

  // Wire bit b -> {valid, index into packed slot frame}; slot s occupies [s*W +: W], MSB first.
  function automatic logic [IW:0] map_bit(input logic [BW-1:0] b);
    int unsigned bi, s, k;
    bi = 32'(b);
    s  = bi / SLOT_BITS;
    k  = bi % SLOT_BITS;
    if (k < W) map_bit = {1'b1, IW'(s * W + W - 1 - k)};
    else       map_bit = '0;
  endfunction

`ifdef CODEC_LOOPBACK_EN
  assign rx_din = sdin;
`else
  assign rx_din = sdout;
`endif

  assign dac_frame = {dac3, dac2, dac1, dac0};

  always_comb begin
    fall_ev     = (div_cnt == DIV_LAST);
    rise_ev     = (div_cnt == DIV_RISE);
    div_nxt     = fall_ev ? '0 : div_cnt + DW'(1);
    bit_nxt     = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
    frame_start = fall_ev && (bit_nxt == '0);
    // bit 0 of a new frame must come straight from dac, the frame register loads on the same edge
    tx_src      = frame_start ? dac_frame : tx_frame;
    tx_map      = map_bit(bit_nxt);
    rx_map      = map_bit(bit_cnt);
    rx_nxt      = rx_frame;
    if (rx_map[IW]) rx_nxt[rx_map[IW-1:0]] = rx_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      bit_cnt    <= BIT_LAST;
      bick       <= 1'b0;
      lrck       <= 1'b0;
      sample_clk <= 1'b0;
      sdin       <= 1'b0;
      tx_frame   <= '0;
      rx_frame   <= '0;
      adc0       <= '0;
      adc1       <= '0;
      adc2       <= '0;
      adc3       <= '0;
    end else begin
      div_cnt <= div_nxt;
      bick    <= (div_nxt >= DIV_HALF);
      if (fall_ev) begin
        bit_cnt    <= bit_nxt;
        lrck       <= (bit_nxt < BIT_HALF);
        sample_clk <= (bit_nxt < BIT_HALF);
        sdin       <= tx_map[IW] ? tx_src[tx_map[IW-1:0]] : 1'b0;
        if (frame_start) tx_frame <= dac_frame;
      end
      if (rise_ev) begin
        rx_frame <= rx_nxt;
        // copy includes the bit sampled this edge, so W == SLOT_BITS also works
        if (bit_cnt == BIT_LAST) begin
          adc0 <= rx_nxt[0*W +: W];
          adc1 <= rx_nxt[1*W +: W];
          adc2 <= rx_nxt[2*W +: W];
          adc3 <= rx_nxt[3*W +: W];
        end
      end
    end
  end

endmodule

// File: tb/tb_codec_tdm_port.sv
// Scoreboard bench for codec_tdm_port: stimulus pushes expected slots/ADC frames, a negedge monitor pops and compares.
// Define CODEC_LOOPBACK_EN for both files to check the loopback build.

module tb_codec_tdm_port;

`ifdef CODEC_LOOPBACK_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic        clk, rst;
  logic        bick, lrck, sdin, sdout, sample_clk;
  logic [15:0] dac0, dac1, dac2, dac3;
  logic [15:0] adc0, adc1, adc2, adc3;

  codec_tdm_port #(.W(16), .SLOT_BITS(32), .N_SLOTS(4), .BCLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .bick(bick), .lrck(lrck), .sdin(sdin), .sdout(sdout),
    .sample_clk(sample_clk),
    .dac0(dac0), .dac1(dac1), .dac2(dac2), .dac3(dac3),
    .adc0(adc0), .adc1(adc1), .adc2(adc2), .adc3(adc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] tx_q[$];
  logic [63:0] adc_q[$];
  logic [15:0] rx_next[4];
  int          tb_bit = 0;
  logic        framed = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor and codec model, all sampled on the falling clk edge
  int          bick_cnt = 0, lrck_cnt = 0, adc_cnt = 0;
  bit          bick_arm = 0, lrck_arm = 0, adc_arm = 0;
  logic        p_bick = 1'b0, p_lrck = 1'b0;
  logic [31:0] slot_sh = '0;
  logic [127:0] rx_wire = '0;

  always @(negedge clk) begin : monitor
    logic br, bf, lr, lf, fr;
    int nb;
    logic [127:0] sh;
    chk("sample_clk==lrck", 64'(sample_clk), 64'(lrck));
    if (rst) begin
      framed   <= 1'b0;
      tb_bit   <= 0;
      p_bick   <= 1'b0;
      p_lrck   <= 1'b0;
      sdout    <= 1'b0;
      bick_arm = 0;
      lrck_arm = 0;
      adc_arm  = 0;
      slot_sh  = '0;
    end else begin
      br = bick & ~p_bick;
      bf = ~bick & p_bick;
      lr = lrck & ~p_lrck;
      lf = ~lrck & p_lrck;
      bick_cnt++;
      lrck_cnt++;
      adc_cnt++;
      nb = tb_bit;
      fr = framed;
      if (br) begin
        if (bick_arm) chk("bick period", 64'(bick_cnt), 64'd4);
        bick_cnt = 0;
        bick_arm = 1;
      end
      if (lr || lf) chk("lrck edge on bick fall", 64'(bf), 64'd1);
      if (lf && lrck_arm) chk("lrck high time", 64'(lrck_cnt), 64'd256);
      if (lr) begin
        if (lrck_arm) chk("lrck period", 64'(lrck_cnt), 64'd512);
        if (adc_arm) chk("adc to sample_clk rise", 64'(adc_cnt), 64'd2);
        lrck_cnt = 0;
        lrck_arm = 1;
        nb = 0;
        fr = 1'b1;
        rx_wire = {rx_next[0], 16'hFFFF, rx_next[1], 16'hFFFF,
                   rx_next[2], 16'hFFFF, rx_next[3], 16'hFFFF};
      end else if (bf && fr) begin
        nb = nb + 1;
      end
      if (fr && (lr || bf)) begin
        sh = rx_wire << nb;
        sdout <= LOOP ? 1'b1 : sh[127];
      end
      if (br && fr) begin
        slot_sh = {slot_sh[30:0], sdin};
        if (nb % 32 == 31) begin
          if (tx_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx slot: got %0h with no expected value queued", slot_sh);
          end else begin
            chk("tx slot", 64'(slot_sh), 64'(tx_q.pop_front()));
          end
        end
        if (nb == 127) begin
          if (adc_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL adc frame: got %0h with no expected value queued", {adc3, adc2, adc1, adc0});
          end else begin
            chk("adc frame", {adc3, adc2, adc1, adc0}, adc_q.pop_front());
          end
          adc_cnt = 0;
          adc_arm = 1;
        end
      end
      tb_bit <= nb;
      framed <= fr;
      p_bick <= bick;
      p_lrck <= lrck;
    end
  end

  task automatic apply(input logic [15:0] d0, d1, d2, d3, r0, r1, r2, r3);
    dac0 = d0; dac1 = d1; dac2 = d2; dac3 = d3;
    rx_next[0] = r0; rx_next[1] = r1; rx_next[2] = r2; rx_next[3] = r3;
    tx_q.push_back({d0, 16'h0000});
    tx_q.push_back({d1, 16'h0000});
    tx_q.push_back({d2, 16'h0000});
    tx_q.push_back({d3, 16'h0000});
    adc_q.push_back(LOOP ? {d3, d2, d1, d0} : {r3, r2, r1, r0});
  endtask

  task automatic wait_bit(input int n);
    int t;
    t = 0;
    while (framed && tb_bit == n && t < 2000) begin @(negedge clk); t++; end
    while (!(framed && tb_bit == n) && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_bit %0d: timed out at tb_bit %0d required %0d", n, tb_bit, n);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " pins"}, 64'({bick, lrck, sdin, sample_clk}), 64'd0);
    chk({tag, " adc"}, {adc3, adc2, adc1, adc0}, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    apply(16'h8001, 16'h1234, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000, 16'h0001, 16'hA5A5);
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    wait_bit(64);
    apply(16'h1111, 16'h5A5A, 16'h0F0F, 16'h7E7E, 16'h1234, 16'hFEDC, 16'h0000, 16'hFFFF);
    wait_bit(40);
    dac0 = 16'h2222;
    wait_bit(64);
    apply(16'h2222, 16'hC3C3, 16'h0001, 16'h8000, 16'h0F0F, 16'hF0F0, 16'h5555, 16'hAAAA);
    wait_bit(64);
    apply(16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h0102, 16'h0304, 16'h0506, 16'h0708);

    wait_bit(70);
    tx_q.delete();
    adc_q.delete();
    #2 rst = 1'b1;
    #1 chk_reset("mid-frame reset");
    apply(16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h8421, 16'h1248, 16'hC001, 16'h3FFC);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    wait_bit(126);
    chk("adc held zero after reset", {adc3, adc2, adc1, adc0}, 64'd0);
    wait_bit(10);
    chk("tx queue drained", 64'(tx_q.size()), 64'd0);
    chk("adc queue drained", 64'(adc_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
